// File: rtl/audio_frame_packer.sv
// Ping-pong framer: fills two sample banks and replays each full bank as a vsync/de burst.
// Optional PACKER_OVF_CNT_EN adds a saturating dropped-sample counter port ovf_cnt.
module audio_frame_packer #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 500,
  parameter int ADDR_W    = 12,
  parameter int VS_LEAD   = 2,
  parameter int VS_TAIL   = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] per_audio_dat,
  input  logic              per_audio_dat_de,
  input  logic              ovf_clr,
  output logic              post_audio_vsync,
  output logic              post_audio_de,
  output logic [DATA_W-1:0] post_voc_data,
  output logic              frame_busy,
  output logic              overflow
`ifdef PACKER_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LEAD, ACTIVE, TAIL} state_t;

  localparam int DEPTH = 2 ** (ADDR_W + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        full, full_set, full_clr;
  logic              wr_bank, rd_bank;
  logic [ADDR_W-1:0] wr_addr, cnt, cnt_n;
  logic              wr_en, wr_last, drop;
  logic              rd_en, rd_done;
  state_t            state, state_n;

  assign wr_en   = per_audio_dat_de & ~full[wr_bank];
  assign drop    = per_audio_dat_de &  full[wr_bank];
  assign wr_last = (wr_addr == ADDR_W'(FRAME_LEN - 1));

  always_ff @(posedge sys_clk)
    if (wr_en) mem[{wr_bank, wr_addr}] <= per_audio_dat;

  // writer only sets a bank that is empty, reader only clears a bank that is full,
  // so set and clear never target the same bank in one cycle
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (wr_en && wr_last) full_set[wr_bank] = 1'b1;
    if (rd_done)          full_clr[rd_bank] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      full     <= '0;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      overflow <= 1'b0;
    end else begin
      full <= (full & ~full_clr) | full_set;
      if (wr_en) begin
        if (wr_last) begin
          wr_addr <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef PACKER_OVF_CNT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                  ovf_cnt <= '0;
    else if (ovf_clr)                ovf_cnt <= drop ? 16'd1 : 16'd0;
    else if (drop && ovf_cnt != '1)  ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_bank <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (rd_done) rd_bank <= ~rd_bank;
    end
  end

  // TAIL starts on the last de cycle, so it spans VS_TAIL+1 cycles
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rd_en   = 1'b0;
    rd_done = 1'b0;
    case (state)
      IDLE: if (full[rd_bank]) begin
        state_n = LEAD;
        cnt_n   = '0;
      end
      LEAD: if (cnt == ADDR_W'(VS_LEAD - 1)) begin
        state_n = ACTIVE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      ACTIVE: begin
        rd_en = 1'b1;
        if (cnt == ADDR_W'(FRAME_LEN - 1)) begin
          state_n = TAIL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TAIL: if (cnt == ADDR_W'(VS_TAIL)) begin
        state_n = IDLE;
        rd_done = 1'b1;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      post_audio_de <= 1'b0;
      post_voc_data <= '0;
    end else begin
      post_audio_de <= rd_en;
      post_voc_data <= rd_en ? mem[{rd_bank, cnt}] : '0;
    end
  end

  assign post_audio_vsync = (state != IDLE);
  assign frame_busy       = (state != IDLE);

endmodule

// File: tb/tb_audio_frame_packer.sv
// Directed bench for audio_frame_packer with FRAME_LEN=8: framing, ordering, overflow, reset abort.
module tb_audio_frame_packer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] per_audio_dat = '0;
  logic        per_audio_dat_de = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        post_audio_vsync, post_audio_de, frame_busy, overflow;
  logic [15:0] post_voc_data;
`ifdef PACKER_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

`define CHK(tag, obs, exp) \
  begin \
    n_vec++; \
    assert ((obs) === (exp)) else begin \
      n_err++; \
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
  end

  audio_frame_packer #(.DATA_W(16), .FRAME_LEN(8), .ADDR_W(4), .VS_LEAD(2), .VS_TAIL(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .per_audio_dat(per_audio_dat), .per_audio_dat_de(per_audio_dat_de), .ovf_clr(ovf_clr),
    .post_audio_vsync(post_audio_vsync), .post_audio_de(post_audio_de),
    .post_voc_data(post_voc_data), .frame_busy(frame_busy), .overflow(overflow)
`ifdef PACKER_OVF_CNT_EN
    , .ovf_cnt(ovf_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc++;

  // output monitor, sampled on the falling edge
  logic [15:0] data_q[$];
  int vs_len_q[$];
  int de_len_q[$];
  int vs_run, de_run, low_run, min_gap, rise_cyc, first_de_cyc, bad_idle;
  bit seen_fall, prev_vs;

  task automatic clr_mon();
    data_q.delete(); vs_len_q.delete(); de_len_q.delete();
    vs_run = 0; de_run = 0; low_run = 0; min_gap = 999; rise_cyc = -1;
    first_de_cyc = -1; bad_idle = 0; seen_fall = 0; prev_vs = 0;
  endtask

  always @(negedge sys_clk) begin
    if (post_audio_de) begin
      if (data_q.size() == 0) first_de_cyc = cyc;
      data_q.push_back(post_voc_data);
      de_run++;
    end else begin
      if (post_voc_data !== 16'h0) bad_idle++;
      if (de_run > 0) de_len_q.push_back(de_run);
      de_run = 0;
    end
    if (post_audio_vsync) begin
      if (!prev_vs) begin
        if (rise_cyc < 0) rise_cyc = cyc;
        if (seen_fall && low_run < min_gap) min_gap = low_run;
      end
      vs_run++;
    end else begin
      if (vs_run > 0) begin
        vs_len_q.push_back(vs_run);
        seen_fall = 1;
        low_run = 0;
      end
      low_run++;
      vs_run = 0;
    end
    prev_vs = post_audio_vsync;
  end

  int last_cyc;

  // entered and left at posedge+1
  task automatic send(input logic [15:0] d, input int gap);
    per_audio_dat_de = 1'b1;
    per_audio_dat = d;
    last_cyc = cyc;
    @(posedge sys_clk); #1;
    per_audio_dat_de = 1'b0;
    per_audio_dat = '0;
    repeat (gap - 1) begin @(posedge sys_clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  initial begin
    bit got_de;
    clr_mon();

    // 1: reset held, no stimulus
    repeat (10) @(posedge sys_clk);
    #1;
    `CHK("rst_vsync", post_audio_vsync, 1'b0)
    `CHK("rst_de", post_audio_de, 1'b0)
    `CHK("rst_data", post_voc_data, 16'h0)
    `CHK("rst_busy", frame_busy, 1'b0)
    `CHK("rst_ovf", overflow, 1'b0)
`ifdef PACKER_OVF_CNT_EN
    `CHK("rst_ovf_cnt", ovf_cnt, 16'h0)
`endif
    sys_rst_n = 1'b1;
    idle(2);
    clr_mon();

    // 2: 8 samples, one every 4 cycles
    for (int i = 1; i <= 8; i++) send(16'(i), 4);
    idle(30);
    `CHK("t2_count", data_q.size(), 8)
    for (int i = 0; i < 8; i++) `CHK("t2_data", data_q[i], 16'(i + 1))
    `CHK("t2_frames", vs_len_q.size(), 1)
    `CHK("t2_vs_len", vs_len_q[0], 13)
    `CHK("t2_de_len", de_len_q[0], 8)
    `CHK("t2_rise", rise_cyc, last_cyc + 2)
    `CHK("t2_first_de", first_de_cyc, last_cyc + 5)
    `CHK("t2_idle_data", bad_idle, 0)
    `CHK("t2_ovf", overflow, 1'b0)
    clr_mon();

    // 3: 24 samples, one every 2 cycles
    for (int i = 1; i <= 24; i++) send(16'(i), 2);
    idle(40);
    `CHK("t3_count", data_q.size(), 24)
    for (int i = 0; i < 24; i++) `CHK("t3_data", data_q[i], 16'(i + 1))
    `CHK("t3_frames", vs_len_q.size(), 3)
    for (int i = 0; i < 3; i++) `CHK("t3_vs_len", vs_len_q[i], 13)
    `CHK("t3_gap_ok", (min_gap >= 1 && min_gap < 999), 1'b1)
    `CHK("t3_idle_data", bad_idle, 0)
    `CHK("t3_ovf", overflow, 1'b0)
    clr_mon();

    // 4: 20 back-to-back samples, the last 4 are dropped
    for (int i = 1; i <= 20; i++) send(16'(i), 1);
    idle(60);
    `CHK("t4_count", data_q.size(), 16)
    for (int i = 0; i < 16; i++) `CHK("t4_data", data_q[i], 16'(i + 1))
    `CHK("t4_frames", vs_len_q.size(), 2)
    `CHK("t4_ovf", overflow, 1'b1)
`ifdef PACKER_OVF_CNT_EN
    `CHK("t4_ovf_cnt", ovf_cnt, 16'd4)
`endif

    // 5: reset pulsed while a frame is streaming
    for (int i = 0; i < 8; i++) send(16'h00F0 + 16'(i), 1);
    got_de = 0;
    for (int i = 0; i < 50 && !got_de; i++) begin
      @(negedge sys_clk);
      got_de = post_audio_de;
    end
    `CHK("t5_de_seen", got_de, 1'b1)
    per_audio_dat_de = 1'b1;
    #1 sys_rst_n = 1'b0;
    #1;
    `CHK("t5_async_vsync", post_audio_vsync, 1'b0)
    `CHK("t5_async_de", post_audio_de, 1'b0)
    `CHK("t5_async_ovf", overflow, 1'b0)
    @(posedge sys_clk); @(posedge sys_clk); #1;
    per_audio_dat_de = 1'b0;
    sys_rst_n = 1'b1;
    idle(2);
    clr_mon();
    for (int i = 0; i < 8; i++) send(16'h00A0 + 16'(i), 1);
    idle(30);
    `CHK("t5_count", data_q.size(), 8)
    for (int i = 0; i < 8; i++) `CHK("t5_data", data_q[i], 16'h00A0 + 16'(i))
    `CHK("t5_frames", vs_len_q.size(), 1)
    `CHK("t5_vs_len", vs_len_q[0], 13)
    `CHK("t5_ovf", overflow, 1'b0)

    // 6: ovf_clr in the same cycle as a drop, then ovf_clr alone
    for (int i = 1; i <= 16; i++) send(16'(i), 1);
    ovf_clr = 1'b1;
    send(16'h0055, 1);
    ovf_clr = 1'b0;
    `CHK("t6_ovf_drop_wins", overflow, 1'b1)
`ifdef PACKER_OVF_CNT_EN
    `CHK("t6_ovf_cnt_one", ovf_cnt, 16'd1)
`endif
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    `CHK("t6_ovf_cleared", overflow, 1'b0)
`ifdef PACKER_OVF_CNT_EN
    `CHK("t6_ovf_cnt_zero", ovf_cnt, 16'd0)
`endif
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
